// File: rtl/fifo_burst_framer_pkg.sv
// framer_pkg: shared state encoding and timer sizing for fifo_burst_framer
package framer_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  function automatic int timer_bits(input int timeout);
    return $clog2(timeout) + 1;
  endfunction
endpackage

// File: rtl/skid_register.sv
// skid_register: 2-entry registered valid/ready buffer; in_ready depends only on registered state
// Ports: clock, reset (async, active-high), in_data/in_valid/in_ready upstream, out_data/out_valid/out_ready downstream
module skid_register #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] skid_data;
  logic         skid_valid;
  assign in_ready = !skid_valid;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (out_ready || !out_valid) begin
      // output slot frees up: drain the skid entry first, otherwise pass input straight through
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      // output stalled: park the beat that was accepted on the strength of the registered ready
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
endmodule

// File: rtl/fifo_burst_framer.sv
// fifo_burst_framer: pulls FIFO words and emits bounded AXI-Stream frames with m_tlast on the final beat
// Ports: clock, reset (async, active-high); level_i/flush_i/s_tvalid/s_tready/s_tdata from/to the FIFO;
//   m_tvalid/m_tready/m_tlast/m_tdata to the sink; busy_o frame in progress; frames_o completed-frame count.
// Macro FRAMER_STATS_EN builds the frames_o counter; without it frames_o is tied to zero.
module fifo_burst_framer
  import framer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ABITS   = 4,
  parameter int MAXLEN  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ABITS-1:0] level_i,
  input  logic             flush_i,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata,
  output logic             busy_o,
  output logic [15:0]      frames_o
);
  localparam int TW = timer_bits(TIMEOUT);
  localparam logic [ABITS-1:0] MAX = ABITS'(MAXLEN);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  if (MAXLEN < 1 || MAXLEN >= (1 << ABITS)) begin : g_bad_maxlen
    $error("fifo_burst_framer: MAXLEN must be within 1..2**ABITS-1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("fifo_burst_framer: TIMEOUT must be at least 2");
  end
  state_t           state;
  logic [TW-1:0]    timer;
  logic [ABITS-1:0] remain;
  logic             skid_ready;
  logic             accept;
  assign busy_o   = state == BURST;
  assign s_tready = busy_o && skid_ready;
  assign accept   = s_tvalid && s_tready;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      remain <= '0;
    end else if (state == IDLE) begin
      // level is snapshotted here; later arrivals wait for the next frame
      if (level_i >= MAX) begin
        state  <= BURST;
        remain <= MAX;
        timer  <= '0;
      end else if (level_i != '0 && (flush_i || timer == TLAST)) begin
        state  <= BURST;
        remain <= level_i;
        timer  <= '0;
      end else begin
        timer <= level_i != '0 ? timer + 1'b1 : '0;
      end
    end else if (accept) begin
      remain <= remain - 1'b1;
      if (remain == 1) state <= IDLE;
    end
  skid_register #(.W(WIDTH + 1)) u_out (
    .clock     (clock),
    .reset     (reset),
    .in_data   ({remain == 1, s_tdata}),
    .in_valid  (s_tvalid && busy_o),
    .in_ready  (skid_ready),
    .out_data  ({m_tlast, m_tdata}),
    .out_valid (m_tvalid),
    .out_ready (m_tready)
  );
`ifdef FRAMER_STATS_EN
  logic [15:0] frames;
  always_ff @(posedge clock or posedge reset)
    if (reset) frames <= '0;
    else if (m_tvalid && m_tready && m_tlast) frames <= frames + 1'b1;
  assign frames_o = frames;
`else
  assign frames_o = 16'h0000;
`endif
endmodule

// File: tb/tb_fifo_burst_framer.sv
// tb_fifo_burst_framer: randomized FIFO-fed stimulus checked against a queue-based frame model
module tb_fifo_burst_framer;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] level_i;
  logic       flush_i;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] s_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic [7:0] m_tdata;
  logic       busy_o;
  logic [15:0] frames_o;

  fifo_burst_framer dut (
    .clock    (clock),
    .reset    (reset),
    .level_i  (level_i),
    .flush_i  (flush_i),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .busy_o   (busy_o),
    .frames_o (frames_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [8:0] exp_q[$];
  bit   mbusy = 0;
  int   mn = 0, mp = 0, mt = 0, lasts = 0;
  bit   stalled = 0;
  logic [8:0] hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    level_i  = 4'(q.size());
    s_tvalid = q.size() != 0;
    s_tdata  = q.size() != 0 ? q[0] : 8'h00;
  endtask

  task automatic start(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, q[i]});
    mbusy = 1; mn = n; mp = 0; mt = 0;
  endtask

  task automatic cycle(input bit push, input logic [7:0] w, input bit fl, input bit rnd);
    bit acc;
    int lvl;
    logic [8:0] e;
    flush_i  = fl;
    m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clock);
    chk("busy", 32'(busy_o), 32'(mbusy));
    if (!mbusy) chk("s_tready_idle", 32'(s_tready), 0);
    if (stalled) begin
      chk("hold_valid", 32'(m_tvalid), 1);
      chk("hold_beat", 32'({m_tlast, m_tdata}), 32'(hold));
    end
    stalled = m_tvalid && !m_tready;
    hold = {m_tlast, m_tdata};
`ifdef FRAMER_STATS_EN
    chk("frames", 32'(frames_o), 32'(lasts[15:0]));
`else
    chk("frames", 32'(frames_o), 0);
`endif
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("beat_expected", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("beat", 32'({m_tlast, m_tdata}), 32'(e));
      end
      if (m_tlast) lasts++;
    end
    lvl = q.size();
    acc = s_tvalid && s_tready;
    if (!mbusy) begin
      if (lvl >= 8) start(8);
      else if (lvl != 0 && fl) start(lvl);
      else if (lvl != 0 && mt == 15) start(lvl);
      else if (lvl != 0) mt++;
      else mt = 0;
    end else if (acc) begin
      mp++;
      if (mp == mn) mbusy = 0;
    end
    @(posedge clock);
    #1;
    if (acc) void'(q.pop_front());
    if (push && q.size() < 15) q.push_back(w);
    drive();
  endtask

  task automatic drain(input bit rnd);
    int k = 0;
    bit done = 0;
    while (!done && k < 400) begin
      cycle(0, 8'h00, 0, rnd);
      k++;
      done = !mbusy && exp_q.size() == 0 && q.size() == 0;
    end
    chk("drained", 32'(done), 1);
  endtask

  initial begin
    int l0, k;
    reset = 1; flush_i = 0; m_tready = 1;
    drive();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_beat", 32'({m_tlast, m_tdata}), 0);
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_frames", 32'(frames_o), 0);
    reset = 0;

    l0 = lasts;
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h10 + i), 0, 0);
    drain(0);
    chk("full_frames", 32'(lasts - l0), 1);

    l0 = lasts;
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h20 + i), 0, 0);
    drain(0);
    chk("timeout_frames", 32'(lasts - l0), 1);

    l0 = lasts;
    cycle(1, 8'h30, 0, 0);
    cycle(1, 8'h31, 0, 0);
    cycle(0, 8'h00, 1, 0);
    chk("flush_started", 32'(mbusy), 1);
    drain(0);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);
    chk("flush_frames", 32'(lasts - l0), 1);

    l0 = lasts;
    for (int i = 0; i < 20; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    drain(0);
    chk("stream_frames", 32'(lasts - l0), 3);

    l0 = lasts;
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h60 + i), 0, 1);
    drain(1);
    chk("stall_frames", 32'(lasts - l0), 1);

    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 19) == 0, 1);
    drain(0);

    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h80 + i), 0, 0);
    k = 0;
    while (mp < 3 && k < 50) begin
      cycle(0, 8'h00, 0, 0);
      k++;
    end
    chk("mid_frame_remain", 32'(mn - mp), 5);
    #1 reset = 1;
    #1;
    chk("arst_m_tvalid", 32'(m_tvalid), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_frames", 32'(frames_o), 0);
    chk("arst_beat", 32'({m_tlast, m_tdata}), 0);
    chk("arst_s_tready", 32'(s_tready), 0);
    #1 reset = 0;
    exp_q.delete();
    mbusy = 0; mt = 0; stalled = 0; lasts = 0;
    drive();
    drain(0);
    chk("post_reset_frames", 32'(lasts), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
